// File: rtl/nn_feature_loader.sv
// nn_feature_loader: binarises a raster pixel stream into a feature vector,
// runs the NeuralNetwork start/done handshake and returns the class on a
// valid/ready result port.
// Ports:
//   clk, rst            clock, async active-high reset
//   pix_valid/ready     pixel stream handshake; pix_data, pix_last payload
//   nn_start            one-cycle start pulse to the network
//   nn_features         binarised frame, stable from START through WAIT
//   nn_done             network done level; nn_prediction its ArgMax class
//   res_valid/ready     result handshake; res_class, res_err payload
//   frame_err           one-cycle pulse after a frame cut short by pix_last
//   frame_cnt           number of results handed off (wrapping)
// Build option: define NN_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES.
module nn_feature_loader #(
    parameter int NUM_PIXELS     = 784,
    parameter int PIX_W          = 8,
    parameter int THRESHOLD      = 128,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [PIX_W-1:0]      pix_data,
    input  logic                  pix_last,
    output logic                  nn_start,
    output logic [NUM_PIXELS-1:0] nn_features,
    input  logic                  nn_done,
    input  logic [3:0]            nn_prediction,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [3:0]            res_class,
    output logic                  res_err,
    output logic                  frame_err,
    output logic [15:0]           frame_cnt
);

    localparam int IDX_W = $clog2(NUM_PIXELS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PIXELS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [PIX_W-1:0] THR      = PIX_W'(THRESHOLD);

    typedef enum logic [1:0] {
        S_LOAD,
        S_START,
        S_WAIT,
        S_OUTPUT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic             done_prev;
    logic             done_edge;
    logic             xfer;
    logic             frame_end;
    logic             early_end;
    logic             handoff;
    logic             timeout;

    // pix_ready is only ever high in LOAD, so xfer implies LOAD
    assign xfer      = pix_valid & pix_ready;
    assign frame_end = xfer & (pix_last | (idx == IDX_LAST));
    assign early_end = xfer & pix_last & (idx != IDX_LAST);
    // a done level left over from the previous run is not an edge
    assign done_edge = nn_done & ~done_prev;
    assign handoff   = res_valid & res_ready;

`ifdef NN_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;

    // held at zero outside WAIT, so every WAIT entry starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (state != S_WAIT)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + CNT_W'(1);
    end

    // a done edge in the final cycle takes priority over the abort
    assign timeout = (state == S_WAIT) & (wait_cnt == CNT_LAST) & ~done_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            res_err <= 1'b0;
        else if ((state == S_WAIT) && done_edge)
            res_err <= 1'b0;
        else if (timeout)
            res_err <= 1'b1;
    end
`else
    // WAIT never aborts; the compare only keeps the parameter referenced
    assign timeout = (TIMEOUT_CYCLES < 0);
    assign res_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_LOAD;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_LOAD:   if (frame_end) state_nxt = S_START;
            S_START:  state_nxt = S_WAIT;
            S_WAIT:   if (done_edge || timeout) state_nxt = S_OUTPUT;
            S_OUTPUT: if (res_ready) state_nxt = S_LOAD;
            default:  state_nxt = S_LOAD;
        endcase
    end

    always_comb begin
        nn_start  = (state == S_START);
        res_valid = (state == S_OUTPUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= '0;
            nn_features <= '0;
            pix_ready   <= 1'b0;
            done_prev   <= 1'b0;
            res_class   <= 4'h0;
            frame_err   <= 1'b0;
            frame_cnt   <= 16'h0;
        end else begin
            done_prev <= nn_done;
            // registered so it reads 0 during reset and 1 one cycle later
            pix_ready <= (state_nxt == S_LOAD);
            frame_err <= early_end;
            if (xfer) begin
                nn_features[idx] <= (pix_data >= THR);
                idx              <= idx + IDX_ONE;
            end
            if ((state == S_WAIT) && done_edge)
                res_class <= nn_prediction;
            else if (timeout)
                res_class <= 4'hF;
            // clearing here leaves untouched bits 0 after an early pix_last
            if (handoff) begin
                nn_features <= '0;
                idx         <= '0;
                frame_cnt   <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_nn_feature_loader.sv
// tb_nn_feature_loader: random pixel frames, a behavioural network model and
// a result scoreboard for nn_feature_loader.
module tb_nn_feature_loader;

    localparam int NP = 784;

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_valid;
    logic          pix_ready;
    logic [7:0]    pix_data;
    logic          pix_last;
    logic          nn_start;
    logic [NP-1:0] nn_features;
    logic          nn_done;
    logic [3:0]    nn_prediction;
    logic          res_valid;
    logic          res_ready;
    logic [3:0]    res_class;
    logic          res_err;
    logic          frame_err;
    logic [15:0]   frame_cnt;

    int            checks = 0;
    int            failures = 0;
    logic [NP-1:0] exp_feat_q[$];
    logic [4:0]    exp_res_q[$];
    logic [15:0]   exp_cnt = 16'd0;
    int            handoffs = 0;
    int            stale_cycles = 0;
    int            force_pred = -1;
    bit            hang = 1'b0;

    nn_feature_loader dut (
        .clk(clk), .rst(rst),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_last(pix_last),
        .nn_start(nn_start), .nn_features(nn_features),
        .nn_done(nn_done), .nn_prediction(nn_prediction),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_class(res_class), .res_err(res_err),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic chk_vec(input string name, input logic [NP-1:0] act,
                           input logic [NP-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_pix_ready"}, 64'(pix_ready), 64'(0));
        chk({tag, "_nn_start"}, 64'(nn_start), 64'(0));
        chk_vec({tag, "_features"}, nn_features, '0);
        chk({tag, "_res_valid"}, 64'(res_valid), 64'(0));
        chk({tag, "_res_class"}, 64'(res_class), 64'(0));
        chk({tag, "_res_err"}, 64'(res_err), 64'(0));
        chk({tag, "_frame_err"}, 64'(frame_err), 64'(0));
        chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(0));
    endtask

    // mode 0 random, 1 bright 0..99, 2 threshold edge then random
    task automatic send_frame(input int mode, input int last_at,
                              input int abort_at,
                              output logic [NP-1:0] exp);
        int         sent = 0;
        int         guard = 0;
        bit         fin = 1'b0;
        logic [7:0] p;
        exp = '0;
        while (!fin) begin
            tick();
            guard++;
            if (guard > 5000) begin
                chk("send_frame_timeout", 64'(sent), 64'(NP));
                return;
            end
            if ($urandom_range(0, 4) == 0) begin
                pix_valid = 1'b0;
                pix_data  = 8'($urandom_range(0, 255));
                pix_last  = 1'($urandom_range(0, 1));
            end else begin
                p = 8'($urandom_range(0, 255));
                if (mode == 1) p = (sent < 100) ? 8'd200 : 8'd10;
                if (mode == 2 && sent < 4) begin
                    case (sent)
                        0: p = 8'd127;
                        1: p = 8'd128;
                        2: p = 8'd255;
                        default: p = 8'd0;
                    endcase
                end
                pix_valid = 1'b1;
                pix_data  = p;
                pix_last  = (sent == last_at);
                if (pix_ready) begin
                    exp[sent] = (p >= 8'd128);
                    if (sent == last_at || sent == NP - 1) fin = 1'b1;
                    sent++;
                    if (sent == abort_at) fin = 1'b1;
                end
            end
        end
    endtask

    task automatic finish_frame(input bit early);
        tick();
        chk("start_latency", 64'(nn_start), 64'(1));
        chk("frame_err_pulse", 64'(frame_err), 64'(early));
        chk("ready_in_start", 64'(pix_ready), 64'(0));
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        tick();
        chk("start_width", 64'(nn_start), 64'(0));
        chk("frame_err_clear", 64'(frame_err), 64'(0));
    endtask

    task automatic wait_handoff(input int target);
        int n = 0;
        while (handoffs < target && n < 300) begin
            tick();
            n++;
        end
        chk("handoff_seen", 64'(handoffs >= target), 64'(1));
    endtask

    task automatic run_frame(input int mode, input int last_at);
        logic [NP-1:0] v;
        int            base = handoffs;
        send_frame(mode, last_at, -1, v);
        exp_feat_q.push_back(v);
        finish_frame(last_at >= 0 && last_at < NP - 1);
        wait_handoff(base + 1);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check_reset(tag);
        exp_feat_q.delete();
        exp_res_q.delete();
        exp_cnt   = 16'd0;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk({tag, "_ready_after"}, 64'(pix_ready), 64'(1));
    endtask

    // network model: checks the vector it is started on, stays done-high
    // for stale_cycles, then drops and rises later with a prediction
    initial begin
        logic [NP-1:0] v;
        int            pr;
        forever begin
            @(negedge clk);
            if (!rst && nn_start) begin
                if (exp_feat_q.size() == 0) begin
                    chk("features_unexpected_start", 64'(1), 64'(0));
                    v = '0;
                end else begin
                    v = exp_feat_q.pop_front();
                    chk_vec("features_at_start", nn_features, v);
                end
                if (hang) begin
                    nn_done = 1'b0;
                end else begin
                    repeat (stale_cycles) @(negedge clk);
                    nn_done = 1'b0;
                    repeat ($urandom_range(1, 8)) @(negedge clk);
                    chk_vec("features_held", nn_features, v);
                    pr = (force_pred >= 0) ? force_pred
                                           : int'($urandom_range(0, 15));
                    nn_prediction = 4'(pr);
                    nn_done       = 1'b1;
                    exp_res_q.push_back({4'(pr), 1'b0});
                end
            end
        end
    end

    // result monitor / scoreboard
    initial begin
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (nn_start || res_valid)
                    chk("ready_while_busy", 64'(pix_ready), 64'(0));
                if (res_valid && res_ready) begin
                    if (exp_res_q.size() == 0) begin
                        chk("result_unexpected", 64'(res_class), 64'(0));
                    end else begin
                        e = exp_res_q.pop_front();
                        chk("res_class", 64'(res_class), 64'(e[4:1]));
                        chk("res_err", 64'(res_err), 64'(e[0]));
                    end
                    chk("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
                    exp_cnt = exp_cnt + 16'd1;
                    handoffs++;
                end
            end
        end
    end

    initial begin
        logic [NP-1:0] v;
        int            base;
        int            n;
        rst = 1'b1;
        pix_valid = 1'b0;
        pix_data = 8'd0;
        pix_last = 1'b0;
        nn_done = 1'b0;
        nn_prediction = 4'd0;
        res_ready = 1'b1;
        #12;
        check_reset("por");
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("ready_after_por", 64'(pix_ready), 64'(1));

        force_pred = 5;
        run_frame(1, -1);
        force_pred = 3;
        run_frame(2, -1);
        // stale done (class 3) held across START, then rise with class 7
        stale_cycles = 3;
        force_pred = 7;
        run_frame(0, 9);
        force_pred = -1;

        for (int i = 0; i < 4; i++) begin
            stale_cycles = $urandom_range(0, 3);
            n = (i == 0) ? NP - 1 : int'($urandom_range(0, NP - 2));
            if (i == 3) n = -1;
            run_frame(0, n);
        end

        // result backpressure
        res_ready = 1'b0;
        base = handoffs;
        send_frame(0, -1, -1, v);
        exp_feat_q.push_back(v);
        finish_frame(1'b0);
        n = 0;
        while (!res_valid && n < 100) begin
            tick();
            n++;
        end
        chk("bp_valid_seen", 64'(res_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            pix_valid = 1'b1;
            pix_data = 8'($urandom_range(0, 255));
            tick();
            chk("bp_valid_held", 64'(res_valid), 64'(1));
            if (exp_res_q.size() > 0)
                chk("bp_class_held", 64'(res_class), 64'(exp_res_q[0][4:1]));
            chk("bp_ready_low", 64'(pix_ready), 64'(0));
        end
        pix_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        chk("bp_ready_after", 64'(pix_ready), 64'(1));
        chk("bp_cnt", 64'(frame_cnt), 64'(exp_cnt));
        chk("bp_handoff", 64'(handoffs), 64'(base + 1));

`ifdef NN_TIMEOUT_EN
        hang = 1'b1;
        base = handoffs;
        send_frame(0, -1, -1, v);
        exp_feat_q.push_back(v);
        exp_res_q.push_back({4'hF, 1'b1});
        finish_frame(1'b0);
        n = 1;
        while (!res_valid && n < 40) begin
            tick();
            n++;
        end
        chk("timeout_latency", 64'(n), 64'(17));
        wait_handoff(base + 1);
        hang = 1'b0;
        run_frame(0, -1);
`endif

        // async reset in the middle of LOAD
        send_frame(0, -1, 400, v);
        do_reset("rst_load");
        run_frame(0, -1);

        // async reset while WAIT is pending
        hang = 1'b1;
        send_frame(0, -1, -1, v);
        exp_feat_q.push_back(v);
        finish_frame(1'b0);
`ifdef NN_TIMEOUT_EN
        repeat (5) tick();
`else
        repeat (40) tick();
`endif
        chk("wait_hold", 64'(res_valid), 64'(0));
        do_reset("rst_wait");
        hang = 1'b0;
        run_frame(2, -1);
        chk("final_cnt", 64'(frame_cnt), 64'(exp_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
